jt89_sched: RTL

- Sequencing and control core for an SN76489-style PSG.
- Decodes CPU latch/data writes into three 10-bit tone registers, four 4-bit attenuations and a 3-bit noise control.
- Advances three tone channels and one noise channel through a single shared 10-bit decrementer, time-multiplexed in a 4-slot sweep started by each clk_en pulse.
- Outputs (square bits, noise bit, volumes) feed the per-channel volume/DAC stages.

---
 rtl/jt89_sched.sv | 85 ++++++++
 1 files changed

// File: rtl/jt89_sched.sv
// jt89_sched: SN76489-style PSG register decode and 4-slot time-multiplexed tone/noise sequencer
module jt89_sched #(
  parameter int SLOTS  = 4,
  parameter int LFSR_W = 16
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        wr,
  input  logic [7:0]  din,
  output logic [2:0]  sq,
  output logic        noise,
  output logic [15:0] vol,
  output logic        busy,
  output logic        overrun
);
  localparam int SW = $clog2(SLOTS);
  localparam logic [LFSR_W-1:0] SEED = {1'b1, {(LFSR_W-1){1'b0}}};
  typedef enum logic {IDLE, RUN} state_t;
  state_t st, st_nx;
  logic [SW-1:0] slot;
  logic [9:0] tone [3];
  logic [9:0] cnt [SLOTS];
  logic [2:0] nctrl, rg, r;
  logic nclk, last, zero, fb;
  logic [LFSR_W-1:0] lfsr;
  logic [9:0] tsel, p, per, nxt;
  assign noise = lfsr[0];
  always_comb begin
    last  = slot == SW'(SLOTS-1);
    st_nx = st == IDLE ? (clk_en ? RUN : IDLE) : (last ? IDLE : RUN);
    tsel  = slot == SW'(0) ? tone[0] : slot == SW'(1) ? tone[1] : tone[2];
    p     = nctrl[1:0] == 2'd0 ? 10'd16 : nctrl[1:0] == 2'd1 ? 10'd32 :
            nctrl[1:0] == 2'd2 ? 10'd64 : (tone[2] <= 10'd1 ? 10'd1 : tone[2]);
    per   = last ? p : tsel;
    zero  = cnt[slot] == 10'd0;
    nxt   = zero ? per : cnt[slot] - 10'd1;
    fb    = nctrl[2] ? lfsr[0] ^ lfsr[3] : lfsr[0];
    r     = din[7] ? din[6:4] : rg;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      slot    <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      sq      <= '0;
      nclk    <= 1'b0;
      lfsr    <= SEED;
      nctrl   <= '0;
      rg      <= '0;
      vol     <= 16'hFFFF;
      tone    <= '{default: '0};
      cnt     <= '{default: '0};
    end else begin
      st   <= st_nx;
      busy <= st_nx == RUN;
      slot <= st == RUN ? slot + 1'b1 : '0;
      if (clk_en && st == RUN) overrun <= 1'b1;
      if (st == RUN) begin
        if (last) begin
          cnt[slot] <= nxt;
          if (zero) begin
            nclk <= ~nclk;
            if (!nclk) lfsr <= {fb, lfsr[LFSR_W-1:1]};
          end
        end else if (tsel <= 10'd1) sq[slot] <= 1'b1;
        else begin
          cnt[slot] <= nxt;
          if (zero) sq[slot] <= ~sq[slot];
        end
      end
      // register writes come last so an LFSR reseed overrides a same-cycle shift
      if (wr) begin
        if (din[7]) rg <= din[6:4];
        if (r[0]) vol[{r[2:1], 2'b00} +: 4] <= din[3:0];
        else if (r == 3'd6) begin
          nctrl <= din[2:0];
          lfsr  <= SEED;
        end else if (din[7]) tone[r[2:1]][3:0] <= din[3:0];
        else tone[r[2:1]][9:4] <= din[5:0];
      end
    end
  end
endmodule
